// File: rtl/ds3_frame_aligner_if.sv
// Serial bit stream in, alignment status out; master drives in/in_en, slave is the aligner.
// No backpressure: the aligner consumes every bit qualified by in_en.
interface ds3_frame_aligner_if #(
  parameter int CW = 10
);
  logic          in;
  logic          in_en;
  logic          out;
  logic          out_valid;
  logic          in_sync;
  logic          frame_start;
  logic          lof;
  logic [CW-1:0] bit_pos;
  logic [1:0]    state;
  logic [15:0]   faw_err_cnt;

  modport master (
    output in, in_en,
    input  out, out_valid, in_sync, frame_start, lof, bit_pos, state, faw_err_cnt
  );

  modport slave (
    input  in, in_en,
    output out, out_valid, in_sync, frame_start, lof, bit_pos, state, faw_err_cnt
  );
endinterface

// File: rtl/ds3_frame_aligner.sv
// DS3/G.752 FAW hunt/presync/sync aligner; all outputs registered, 1 clk after the consumed bit.
// No backpressure: in_en gates every advance. Define FAW_ERRCNT_EN to build the FAW bit-error counter.
module ds3_frame_aligner #(
  parameter int                 FAW_LEN    = 8,
  parameter logic [FAW_LEN-1:0] FAW        = 8'b10011001,
  parameter int                 FRAME_BITS = 1000,
  parameter int                 CONFIRM_N  = 2,
  parameter int                 LOSS_N     = 4
) (
  input logic                clk,
  input logic                reset,
  ds3_frame_aligner_if.slave bus
);

  localparam int             CW        = $clog2(FRAME_BITS);
  localparam logic [CW-1:0]  LAST_POS  = CW'(FRAME_BITS - 1);
  localparam logic [2:0]     CONFIRM_C = 3'(CONFIRM_N);
  localparam logic [3:0]     LOSS_C    = 4'(LOSS_N);

  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    PRESYNC = 2'b01,
    SYNC    = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [FAW_LEN-2:0] sr_q, sr_d;
  logic [CW-1:0]      bit_pos_q, bit_pos_d;
  logic [2:0]         confirm_cnt_q, confirm_cnt_d;
  logic [3:0]         miss_cnt_q, miss_cnt_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               lof_q, lof_d;

  logic [FAW_LEN-1:0] window;
  logic               hit;
  logic               check;
  logic [CW-1:0]      pos_inc;
  logic [2:0]         confirm_inc;
  logic [3:0]         miss_inc;

  // The history register keeps FAW_LEN-1 bits; the live input completes the word.
  assign window      = {sr_q, bus.in};
  assign hit         = (window == FAW);
  assign pos_inc     = (bit_pos_q == LAST_POS) ? '0 : bit_pos_q + CW'(1);
  assign check       = (pos_inc == '0);
  assign confirm_inc = confirm_cnt_q + 3'd1;
  assign miss_inc    = miss_cnt_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_pos_d     = bit_pos_q;
    confirm_cnt_d = confirm_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    out_d         = out_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    lof_d         = 1'b0;

    if (bus.in_en) begin
      sr_d        = window[FAW_LEN-2:0];
      out_d       = bus.in;
      out_valid_d = (state_q == SYNC);

      case (state_q)
        HUNT: begin
          bit_pos_d = '0;
          if (hit) begin
            state_d       = PRESYNC;
            confirm_cnt_d = '0;
          end
        end

        PRESYNC: begin
          bit_pos_d = pos_inc;
          if (check) begin
            if (!hit) begin
              // A miss cannot restart the hunt on this same bit, so HUNT idles at 0.
              state_d   = HUNT;
              bit_pos_d = '0;
            end else if (confirm_inc == CONFIRM_C) begin
              state_d       = SYNC;
              confirm_cnt_d = '0;
              miss_cnt_d    = '0;
            end else begin
              confirm_cnt_d = confirm_inc;
            end
          end
        end

        SYNC: begin
          bit_pos_d = pos_inc;
          if (check) begin
            if (hit) begin
              miss_cnt_d    = '0;
              frame_start_d = 1'b1;
            end else if (miss_inc == LOSS_C) begin
              state_d    = HUNT;
              miss_cnt_d = '0;
              lof_d      = 1'b1;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end

        default: begin
          state_d   = HUNT;
          bit_pos_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      bit_pos_q     <= '0;
      confirm_cnt_q <= '0;
      miss_cnt_q    <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      lof_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_pos_q     <= bit_pos_d;
      confirm_cnt_q <= confirm_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      lof_q         <= lof_d;
    end
  end

`ifdef FAW_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [5:0]  err_bits;
  logic [16:0] err_sum;

  always_comb begin
    err_bits = '0;
    for (int i = 0; i < FAW_LEN; i++) begin
      err_bits = err_bits + 6'(window[i] ^ FAW[i]);
    end
    err_sum   = {1'b0, err_cnt_q} + 17'(err_bits);
    err_cnt_d = err_cnt_q;
    if (bus.in_en && (state_q == SYNC) && check) begin
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.faw_err_cnt = err_cnt_q;
`else
  assign bus.faw_err_cnt = 16'h0000;
`endif

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.in_sync     = (state_q == SYNC);
  assign bus.frame_start = frame_start_q;
  assign bus.lof         = lof_q;
  assign bus.bit_pos     = bit_pos_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_ds3_frame_aligner.sv
// Randomized-payload bench for ds3_frame_aligner against a frame-arithmetic reference model.
module tb_ds3_frame_aligner;

  localparam logic [7:0] FAW = 8'b10011001;
  localparam int         FB  = 1000;
  localparam int         CN  = 2;
  localparam int         LN  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ds3_frame_aligner_if #(.CW(10)) bus();

  ds3_frame_aligner #(
    .FAW_LEN(8), .FAW(FAW), .FRAME_BITS(FB), .CONFIRM_N(CN), .LOSS_N(LN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame position is (enabled-bit index - anchor) mod FB.
  bit hist[$];
  int m_mode, m_anchor, m_hits, m_misses, m_err, m_pos;
  bit m_fs, m_lof, m_out, m_ovld;

  typedef struct {
    bit b;
    int tag;
  } sbit_t;
  sbit_t      stim[$];
  logic [7:0] gw;

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_anchor = 0; m_hits = 0; m_misses = 0; m_err = 0; m_pos = 0;
    m_fs = 0; m_lof = 0; m_out = 0; m_ovld = 0;
    gw = 8'h00;
  endtask

  function automatic logic [7:0] model_window();
    logic [7:0] w = 8'h00;
    int n = hist.size() - 1;
    for (int k = 0; k < 8; k++) begin
      int idx = n - 7 + k;
      w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_bit(input bit b);
    int         n;
    logic [7:0] w;
    bit         h, at_chk;
    hist.push_back(b);
    n      = hist.size() - 1;
    w      = model_window();
    h      = (w == FAW);
    at_chk = (m_mode != 0) && (((n - m_anchor) % FB) == 0);
    m_fs   = 0;
    m_lof  = 0;
    m_ovld = (m_mode == 2);
    m_out  = b;
    if (m_mode == 0) begin
      if (h) begin
        m_mode = 1; m_anchor = n; m_hits = 0;
      end
    end else if (at_chk) begin
      if (m_mode == 1) begin
        if (h) begin
          m_hits++;
          if (m_hits == CN) begin
            m_mode = 2; m_misses = 0;
          end
        end else begin
          m_mode = 0;
        end
      end else begin
        m_err = m_err + $countones(w ^ FAW);
        if (m_err > 65535) m_err = 65535;
        if (h) begin
          m_misses = 0; m_fs = 1;
        end else begin
          m_misses++;
          if (m_misses == LN) begin
            m_mode = 0; m_lof = 1; m_misses = 0;
          end
        end
      end
    end
    m_pos = (m_mode == 0) ? 0 : ((n - m_anchor) % FB);
  endtask

  function automatic logic [32:0] exp_vec();
    logic [15:0] e;
`ifdef FAW_ERRCNT_EN
    e = 16'(m_err);
`else
    e = 16'h0000;
`endif
    return {2'(m_mode), (m_mode == 2), m_fs, m_lof, 10'(m_pos), m_ovld, m_out, e};
  endfunction

  function automatic logic [32:0] act_vec();
    return {bus.state, bus.in_sync, bus.frame_start, bus.lof, bus.bit_pos,
            bus.out_valid, bus.out, bus.faw_err_cnt};
  endfunction

  // Stream builder: payload never forms the FAW, and the 4 bits ahead of a FAW are
  // zero so no partial overlap with the pattern can complete early.
  task automatic add_bit(input bit b, input int tag);
    gw = {gw[6:0], b};
    stim.push_back('{b, tag});
  endtask

  task automatic add_payload(input int nb);
    for (int i = 0; i < nb; i++) begin
      bit b = 1'($urandom);
      if ({gw[6:0], b} == FAW) b = ~b;
      if (i >= nb - 4) b = 1'b0;
      add_bit(b, 0);
    end
  endtask

  task automatic add_faw(input bit corrupt, input int tag);
    logic [7:0] w = FAW;
    if (corrupt) w = w ^ 8'b0010_0010;
    for (int k = 7; k >= 0; k--) add_bit(w[k], (k == 0) ? tag : 0);
  endtask

  task automatic send_bit(input bit b, input bit en);
    bus.in    = b;
    bus.in_en = en;
    @(posedge clk);
    #1;
    if (en) model_bit(b);
    else begin
      m_fs = 0; m_lof = 0; m_ovld = 0;
    end
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    bus.in    = 1'($urandom);
    bus.in_en = 1'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in    = 1'($urandom);
      bus.in_en = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (act_vec() !== 33'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, act_vec());
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_acquire();
    sbit_t s;
    stim.delete();
    for (int f = 1; f <= 5; f++) begin
      add_payload(992);
      add_faw(1'b0, f);
    end
    while (stim.size() > 0) begin
      s = stim.pop_front();
      send_bit(s.b, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL acquire_cycle: got %h expected %h", act_vec(), exp_vec());
      end
      if (s.tag == 1 || s.tag == 2) begin
        checks++;
        if (bus.state !== 2'b01) begin
          errors++;
          $display("FAIL acquire_presync faw%0d: state %b expected 01", s.tag, bus.state);
        end
      end
      if (s.tag == 3) begin
        checks++;
        if ({bus.in_sync, bus.frame_start} !== 2'b10) begin
          errors++;
          $display("FAIL acquire_sync: in_sync/frame_start %b expected 10",
                   {bus.in_sync, bus.frame_start});
        end
      end
      if (s.tag >= 4) begin
        checks++;
        if ({bus.frame_start, bus.bit_pos} !== {1'b1, 10'd0}) begin
          errors++;
          $display("FAIL acquire_frame_start faw%0d: fs %b pos %0d expected fs 1 pos 0",
                   s.tag, bus.frame_start, bus.bit_pos);
        end
      end
    end
  endtask

  task automatic test_loss();
    sbit_t s;
    stim.delete();
    for (int f = 11; f <= 13; f++) begin
      add_payload(992);
      add_faw(1'b1, f);
    end
    add_payload(992);
    add_faw(1'b0, 14);
    for (int f = 21; f <= 24; f++) begin
      add_payload(992);
      add_faw(1'b1, f);
    end
    while (stim.size() > 0) begin
      s = stim.pop_front();
      send_bit(s.b, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL loss_cycle: got %h expected %h", act_vec(), exp_vec());
      end
      if ((s.tag >= 11 && s.tag <= 13) || (s.tag >= 21 && s.tag <= 23)) begin
        checks++;
        if ({bus.in_sync, bus.lof} !== 2'b10) begin
          errors++;
          $display("FAIL loss_hold tag%0d: in_sync/lof %b expected 10", s.tag,
                   {bus.in_sync, bus.lof});
        end
      end
      if (s.tag == 14) begin
        checks++;
        if ({bus.in_sync, bus.frame_start} !== 2'b11) begin
          errors++;
          $display("FAIL loss_recover: in_sync/frame_start %b expected 11",
                   {bus.in_sync, bus.frame_start});
        end
      end
      if (s.tag == 24) begin
        checks++;
        if ({bus.lof, bus.in_sync, bus.state} !== 4'b1000) begin
          errors++;
          $display("FAIL loss_lof: lof/in_sync/state %b expected 1000",
                   {bus.lof, bus.in_sync, bus.state});
        end
      end
    end
  endtask

  task automatic test_stray();
    sbit_t s;
    reset_dut();
    stim.delete();
    add_payload(300);
    add_faw(1'b0, 31);
    add_payload(492);
    add_faw(1'b0, 34);
    for (int f = 0; f < 3; f++) begin
      add_payload(992);
      add_faw(1'b0, (f == 2) ? 33 : 0);
    end
    stim[1307].tag = 32;
    while (stim.size() > 0) begin
      s = stim.pop_front();
      send_bit(s.b, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stray_cycle: got %h expected %h", act_vec(), exp_vec());
      end
      if (s.tag == 31 || s.tag == 34) begin
        checks++;
        if (bus.state !== 2'b01) begin
          errors++;
          $display("FAIL stray_presync tag%0d: state %b expected 01", s.tag, bus.state);
        end
      end
      if (s.tag == 32) begin
        checks++;
        if ({bus.state, bus.bit_pos} !== {2'b00, 10'd0}) begin
          errors++;
          $display("FAIL stray_hunt: state %b pos %0d expected 00 pos 0", bus.state, bus.bit_pos);
        end
      end
      if (s.tag == 33) begin
        checks++;
        if (bus.in_sync !== 1'b1) begin
          errors++;
          $display("FAIL stray_reacquire: in_sync %b expected 1", bus.in_sync);
        end
      end
    end
  endtask

  task automatic test_in_en();
    sbit_t s;
    reset_dut();
    stim.delete();
    for (int f = 1; f <= 5; f++) begin
      add_payload(992);
      add_faw(1'b0, f);
    end
    while (stim.size() > 0) begin
      s = stim.pop_front();
      send_bit(s.b, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL in_en_on_cycle: got %h expected %h", act_vec(), exp_vec());
      end
      if (s.tag == 3) begin
        checks++;
        if (bus.in_sync !== 1'b1) begin
          errors++;
          $display("FAIL in_en_sync: in_sync %b expected 1", bus.in_sync);
        end
      end
      send_bit(1'($urandom), 1'b0);
      checks++;
      if ({bus.frame_start, bus.lof, bus.out_valid} !== 3'b000 || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL in_en_off_cycle: got %h expected %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    sbit_t       s;
    logic [15:0] err_exp;
`ifdef FAW_ERRCNT_EN
    err_exp = 16'd2;
`else
    err_exp = 16'd0;
`endif
    stim.delete();
    add_payload(992);
    add_faw(1'b1, 41);
    add_payload(992);
    add_faw(1'b0, 42);
    add_payload(500);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      send_bit(s.b, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_cycle: got %h expected %h", act_vec(), exp_vec());
      end
      if (s.tag == 41) begin
        checks++;
        if (bus.faw_err_cnt !== err_exp) begin
          errors++;
          $display("FAIL faw_err_cnt: got %0d expected %0d", bus.faw_err_cnt, err_exp);
        end
      end
    end
    checks++;
    if ({bus.in_sync, bus.bit_pos} !== {1'b1, 10'd500}) begin
      errors++;
      $display("FAIL mid_position: in_sync %b pos %0d expected 1 pos 500", bus.in_sync, bus.bit_pos);
    end
    reset     = 1'b1;
    bus.in    = 1'($urandom);
    bus.in_en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.state, bus.in_sync, bus.faw_err_cnt} !== 19'h0 || act_vec() !== 33'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h expected 0", act_vec());
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset     = 1'b1;
    bus.in    = 1'b0;
    bus.in_en = 1'b0;
    model_reset();
    test_reset();
    test_acquire();
    test_loss();
    test_stray();
    test_in_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
